cordic_quad_restore: RTL and testbench
======================================

Name: cordic_quad_restore

Overview:
- Output-side counterpart of the vectoring-mode quadrant capture in the CORDIC datapath.
- At CORDIC input, records each sample's quadrant code {y_MSB,x_MSB} in a FIFO, because the front end folds the vector into quadrant 1.
- When the matching CORDIC result emerges, pops the code and maps the first-quadrant angle back to the full-circle angle.
- Absorbs the CORDIC pipeline latency, so any number of samples up to DEPTH may be in flight.

Parameters:
- ANGLE_W, 16: angle/magnitude width. Binary-angle format: 2^(ANGLE_W-1) represents pi; signed two's complement.
- DEPTH, 16: FIFO depth. Power of 2, at least 2, and at least the CORDIC pipeline latency.
- CNT_W, 5: occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample enters CORDIC this cycle; push quadrant code.
- x_in_MSB  in  1  sign of input x, valid with in_valid.
- y_in_MSB  in  1  sign of input y, valid with in_valid.
- res_valid  in  1  CORDIC result valid this cycle; pop quadrant code.
- theta_in  in  ANGLE_W  first-quadrant angle, range 0..2^(ANGLE_W-2).
- mag_in  in  ANGLE_W  magnitude, passed through.
- out_valid  out  1  registered result valid.
- angle_out  out  ANGLE_W  full-circle angle.
- mag_out  out  ANGLE_W  magnitude, delayed one cycle.
- quad_out  out  2  code applied to the current output.
- fifo_count  out  CNT_W  codes in flight.
- ovf_err  out  1  sticky: push dropped because FIFO was full.
- unf_err  out  1  sticky: pop with no code available.

Behaviour:
- Reset (async, active-high): FIFO pointers = 0, fifo_count = 0; out_valid, angle_out, mag_out, quad_out, ovf_err and unf_err all = 0.
- Push: on in_valid, write {y_in_MSB,x_in_MSB} at the write pointer. Pointers wrap modulo DEPTH.
- Pop: on res_valid, read the code at the read pointer.
- Correction (combinational on popped code q; theta = theta_in; arithmetic modulo 2^ANGLE_W, P = 2^(ANGLE_W-1)):
  - q=00 -> theta
  - q=01 -> P - theta
  - q=11 -> theta - P
  - q=10 -> -theta
- Output stage: one register stage. In the cycle after res_valid:
  - out_valid = 1;
  - angle_out is the corrected angle;
  - mag_out = mag_in;
  - quad_out = q.
- When res_valid = 0, out_valid = 0 next cycle; data outputs hold their previous values.
- Latency: res_valid to out_valid is exactly 1 cycle. Throughput is 1 result per cycle.
- Simultaneous push and pop:
  - Not empty: both proceed; count unchanged; the popped code is the oldest one.
  - Empty: bypass; the incoming code is used directly; count stays 0; no underflow.
  - Full: both proceed; no overflow.
- Full, push without pop: the code is dropped; ovf_err is set; pointers and count are unchanged.
- Empty, pop without push: q is forced to 00; out_valid is still asserted; unf_err is set; pointers are unchanged.
- ovf_err and unf_err are cleared only by reset.
- Edge values:
  - theta = 0 with q=01 gives P (0x8000 for W=16), the same point as -pi.
  - theta = 0 with q=10 gives 0.
- Reset mid-operation discards all in-flight codes immediately. Outputs are 0 from the reset assertion edge.

Test Plan:
- W=16; push codes 00, 01, 11, 10 on consecutive cycles; 4 cycles later pop 4 with theta_in = 0x2000 -> angle_out = 0x2000, 0x6000, 0xA000, 0xE000 on 4 consecutive out_valid cycles; quad_out matches each code.
- Continuous streaming: push 1 per cycle, pop 1 per cycle with lag 12, 100 random codes -> every output follows its code in order; fifo_count holds at 12; no error flags set.
- Empty with push+pop in the same cycle, code 10, theta_in = 0x1000 -> next cycle angle_out = 0xF000; fifo_count = 0; unf_err = 0.
- 16 pushes, then a 17th push with no pop -> ovf_err = 1; fifo_count = 16; the next 16 pops return the first 16 codes.
- Pop while empty with no push, theta_in = 0x0800 -> out_valid = 1, angle_out = 0x0800, quad_out = 00, unf_err = 1 and sticky.
- Assert reset with 5 codes in flight -> all outputs 0 immediately; fifo_count = 0; after release, the first pop with no push sets unf_err.

Source files
------------

// File: rtl/cordic_quad_restore.sv
// Restores the full-circle angle of a vectoring-mode CORDIC result from the
// quadrant code captured when the sample entered the CORDIC pipeline.
module cordic_quad_restore #(
  parameter int ANGLE_W = 16,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      x_in_MSB,
  input  logic                      y_in_MSB,
  input  logic                      res_valid,
  input  logic signed [ANGLE_W-1:0] theta_in,
  input  logic signed [ANGLE_W-1:0] mag_in,
  output logic                      out_valid,
  output logic signed [ANGLE_W-1:0] angle_out,
  output logic signed [ANGLE_W-1:0] mag_out,
  output logic [1:0]                quad_out,
  output logic [CNT_W-1:0]          fifo_count,
  output logic                      ovf_err,
  output logic                      unf_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic signed [ANGLE_W-1:0] PI_ANG = {1'b1, {(ANGLE_W-1){1'b0}}};

  // Maps a first-quadrant angle back into the quadrant the front end folded
  // it out of. Wraps modulo 2^ANGLE_W, so theta=0 in quadrant 2 lands on -pi.
  function automatic logic signed [ANGLE_W-1:0] quad_correct(
    input logic [1:0]                q,
    input logic signed [ANGLE_W-1:0] th
  );
    logic signed [ANGLE_W-1:0] r;
    case (q)
      2'b00:   r = th;
      2'b01:   r = PI_ANG - th;
      2'b11:   r = th - PI_ANG;
      default: r = -th;
    endcase
    return r;
  endfunction

  logic [1:0]                code_mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;

  logic                      empty;
  logic                      full;
  logic                      bypass;
  logic                      do_write;
  logic                      do_read;
  logic                      set_ovf;
  logic                      set_unf;
  logic [1:0]                push_code;

  logic                      vld_p0;
  logic [1:0]                q_p0;
  logic signed [ANGLE_W-1:0] angle_p0;

  logic                      vld_p1;
  logic [1:0]                quad_p1;
  logic signed [ANGLE_W-1:0] angle_p1;
  logic signed [ANGLE_W-1:0] mag_p1;

  // Stage p0: FIFO control, code selection and quadrant correction
  always_comb begin
    push_code = {y_in_MSB, x_in_MSB};
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    // An empty FIFO with a simultaneous push hands the new code straight through.
    bypass    = in_valid & res_valid & empty;
    do_read   = res_valid & ~empty;
    do_write  = in_valid & ~bypass & (~full | res_valid);
    set_ovf   = in_valid & ~res_valid & full;
    set_unf   = res_valid & ~in_valid & empty;
    vld_p0    = res_valid;
    q_p0      = 2'b00;
    if (bypass) begin
      q_p0 = push_code;
    end else if (do_read) begin
      q_p0 = code_mem[rd_ptr];
    end
    angle_p0 = quad_correct(q_p0, theta_in);
  end

  // Storage is data only; occupancy tracking keeps stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_write) begin
      code_mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (set_ovf) begin
        ovf_err <= 1'b1;
      end
      if (set_unf) begin
        unf_err <= 1'b1;
      end
    end
  end

  // Stage p1: registered result; data holds between results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      quad_p1  <= 2'b00;
      angle_p1 <= '0;
      mag_p1   <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        quad_p1  <= q_p0;
        angle_p1 <= angle_p0;
        mag_p1   <= mag_in;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign angle_out  = angle_p1;
  assign mag_out    = mag_p1;
  assign quad_out   = quad_p1;
  assign fifo_count = count;

endmodule

// File: tb/tb_cordic_quad_restore.sv
// Directed bench for cordic_quad_restore: quadrant mapping, streaming, bypass,
// overflow/underflow flags and asynchronous reset.
module tb_cordic_quad_restore;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         x_in_MSB = 1'b0;
  logic         y_in_MSB = 1'b0;
  logic         res_valid = 1'b0;
  logic [W-1:0] theta_in = '0;
  logic [W-1:0] mag_in = '0;
  logic         out_valid;
  logic [W-1:0] angle_out;
  logic [W-1:0] mag_out;
  logic [1:0]   quad_out;
  logic [4:0]   fifo_count;
  logic         ovf_err;
  logic         unf_err;

  int checks = 0;
  int errors = 0;

  logic [1:0]   mq[$];
  logic [1:0]   code;
  logic [1:0]   qexp;
  logic [W-1:0] th;
  logic [W-1:0] eang;
  logic         push;
  logic         pop;
  logic [1:0]   codes4 [4];
  logic [W-1:0] angs4 [4];

  cordic_quad_restore #(.ANGLE_W(W), .DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in_MSB(x_in_MSB),
    .y_in_MSB(y_in_MSB), .res_valid(res_valid), .theta_in(theta_in),
    .mag_in(mag_in), .out_valid(out_valid), .angle_out(angle_out),
    .mag_out(mag_out), .quad_out(quad_out), .fifo_count(fifo_count),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [1:0] c, input logic r,
                       input logic [W-1:0] t, input logic [W-1:0] m);
    in_valid  = p;
    y_in_MSB  = c[1];
    x_in_MSB  = c[0];
    res_valid = r;
    theta_in  = t;
    mag_in    = m;
  endtask

  function automatic logic [W-1:0] exp_angle(input logic [1:0] q, input logic [W-1:0] t);
    case (q)
      2'b00:   return t;
      2'b01:   return 16'h8000 - t;
      2'b11:   return t - 16'h8000;
      default: return 16'h0000 - t;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    codes4 = '{2'b00, 2'b01, 2'b11, 2'b10};
    angs4  = '{16'h2000, 16'h6000, 16'hA000, 16'hE000};

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_angle", angle_out, 0);
    check("rst_mag", mag_out, 0);
    check("rst_quad", quad_out, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_unf", unf_err, 0);
    @(negedge clk) reset = 1'b0;

    // Four quadrants with theta = 0x2000
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, codes4[i], 1'b0, '0, '0);
      tick();
    end
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    check("quad4_count", fifo_count, 4);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b00, 1'b1, 16'h2000, 16'h0100 + 16'(i));
      tick();
      check("quad4_valid", out_valid, 1);
      check("quad4_angle", angle_out, angs4[i]);
      check("quad4_quad", quad_out, codes4[i]);
      check("quad4_mag", mag_out, 32'h0100 + 32'(i));
    end
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    tick();
    check("idle_valid", out_valid, 0);
    check("idle_hold", angle_out, 16'hE000);
    check("idle_count", fifo_count, 0);

    // Streaming with a 12-sample lag
    mq.delete();
    for (int i = 0; i < 112; i++) begin
      push = (i < 100);
      pop  = (i >= 12);
      code = 2'($urandom_range(0, 3));
      th   = 16'($urandom_range(0, 16384));
      if (push) mq.push_back(code);
      qexp = 2'b00;
      if (pop) qexp = mq.pop_front();
      eang = exp_angle(qexp, th);
      drive(push, code, pop, th, 16'(i));
      tick();
      if (pop) begin
        check("stream_valid", out_valid, 1);
        check("stream_angle", angle_out, eang);
        check("stream_quad", quad_out, qexp);
      end
      if (i >= 11 && i < 100) check("stream_count", fifo_count, 12);
    end
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    tick();
    check("stream_ovf", ovf_err, 0);
    check("stream_unf", unf_err, 0);
    check("stream_cnt_end", fifo_count, 0);

    // Empty FIFO, push and pop together
    drive(1'b1, 2'b10, 1'b1, 16'h1000, 16'h0055);
    tick();
    check("bypass_valid", out_valid, 1);
    check("bypass_angle", angle_out, 16'hF000);
    check("bypass_quad", quad_out, 2'b10);
    check("bypass_count", fifo_count, 0);
    check("bypass_unf", unf_err, 0);

    // Fill, push+pop at full, then overflow
    mq.delete();
    for (int i = 0; i < 16; i++) begin
      code = 2'((i * 7 + 1) % 4);
      mq.push_back(code);
      drive(1'b1, code, 1'b0, '0, '0);
      tick();
    end
    check("full_count", fifo_count, 16);
    check("full_ovf0", ovf_err, 0);
    qexp = mq.pop_front();
    mq.push_back(2'b11);
    drive(1'b1, 2'b11, 1'b1, 16'h0400, '0);
    tick();
    check("fullpp_quad", quad_out, qexp);
    check("fullpp_angle", angle_out, exp_angle(qexp, 16'h0400));
    check("fullpp_count", fifo_count, 16);
    check("fullpp_ovf", ovf_err, 0);
    drive(1'b1, 2'b01, 1'b0, '0, '0);
    tick();
    check("ovf_flag", ovf_err, 1);
    check("ovf_count", fifo_count, 16);
    for (int i = 0; i < 16; i++) begin
      qexp = mq.pop_front();
      drive(1'b0, 2'b00, 1'b1, 16'h0300, '0);
      tick();
      check("drain_quad", quad_out, qexp);
      check("drain_angle", angle_out, exp_angle(qexp, 16'h0300));
    end
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    tick();
    check("drain_count", fifo_count, 0);
    check("drain_ovf_sticky", ovf_err, 1);

    // Underflow
    drive(1'b0, 2'b00, 1'b1, 16'h0800, 16'h0077);
    tick();
    check("unf_valid", out_valid, 1);
    check("unf_angle", angle_out, 16'h0800);
    check("unf_quad", quad_out, 2'b00);
    check("unf_flag", unf_err, 1);
    check("unf_count", fifo_count, 0);
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    tick();
    check("unf_sticky", unf_err, 1);

    // Reset with codes in flight
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b01, 1'b0, '0, '0);
      tick();
    end
    drive(1'b0, 2'b00, 1'b1, 16'h0200, 16'h0033);
    tick();
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    check("pre_rst_angle", angle_out, 16'h7E00);
    check("pre_rst_count", fifo_count, 4);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_angle", angle_out, 0);
    check("mid_rst_mag", mag_out, 0);
    check("mid_rst_quad", quad_out, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ovf", ovf_err, 0);
    check("mid_rst_unf", unf_err, 0);
    @(negedge clk) reset = 1'b0;
    drive(1'b0, 2'b00, 1'b1, 16'h0900, '0);
    tick();
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    check("post_rst_unf", unf_err, 1);
    check("post_rst_quad", quad_out, 2'b00);
    check("post_rst_angle", angle_out, 16'h0900);
    check("post_rst_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
